counter_share_arbiter: RTL and testbench

//  Round-robin controller that time-shares one external CW-bit synchronous up-counter among NREQ requesters.

---
 rtl/counter_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_counter_share_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter time-sharing one external CW-bit up-counter among NREQ requesters.
// Optional watchdog abort of stuck runs is built when WATCHDOG_EN is defined.
module counter_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   req_len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 cnt_clr,
  output logic                 cnt_en,
  input  logic [CW-1:0]        cnt_q,
  output logic                 err
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST   = IW'(NREQ-1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DONE, ABORT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, w_r, w_nxt, win;
  logic [IW:0]     scan;
  logic            found;
  logic [CW-1:0]   len_r, sel_len, len_m1;
  logic            held, terminal;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winner search: first set request starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!found && req[scan[IW-1:0]]) begin
        win   = scan[IW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == IW'(i)) sel_len = req_len[i*CW +: CW];
  end

  assign held     = req[w_r];
  assign len_m1   = len_r - CW'(1);
  assign terminal = (cnt_q == len_m1);

`ifdef WATCHDOG_EN
  localparam logic [CW:0] WD_LIM = {1'b1, {CW{1'b0}}};
  logic [CW:0] wd;
  logic        wd_hit;

  // wd holds the number of RUN cycles already elapsed in the current run
  always_ff @(posedge clk) begin
    if (state != RUN) wd <= '0;
    else              wd <= wd + 1'b1;
  end

  assign wd_hit = (wd == WD_LIM);
`endif

  always_comb begin
    state_nxt = state;
    w_nxt     = w_r;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = CLR;
          w_nxt     = win;
        end
      end
      CLR: begin
        if (!held)              state_nxt = IDLE;
        else if (len_r == '0)   state_nxt = DONE;
        else                    state_nxt = RUN;
      end
      RUN: begin
        if (!held)         state_nxt = IDLE;
        else if (terminal) state_nxt = DONE;
        else begin
          cnt_en = 1'b1;
`ifdef WATCHDOG_EN
          if (wd_hit) state_nxt = ABORT;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they align with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= (state_nxt != IDLE) ? onehot(w_nxt) : '0;
      done    <= (state_nxt == DONE) ? onehot(w_nxt) : '0;
      busy    <= (state_nxt != IDLE);
      cnt_clr <= (state_nxt == CLR);
      if (state != IDLE && state_nxt == IDLE)
        rr_ptr <= (w_r == LAST) ? '0 : w_r + 1'b1;
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= (state_nxt == ABORT);
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      w_r   <= win;
      len_r <= sel_len;
    end
  end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter with a behavioural shared counter.
// Exercises the WATCHDOG_EN abort path when that macro is defined.
module tb_counter_share_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] req_len;
  logic [NREQ-1:0]   gnt, done;
  logic              busy, cnt_clr, cnt_en, err;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt = '0;
  logic              force0;

  int tests = 0;
  int fails = 0;

  counter_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .cnt_q(cnt_q), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr)     cnt <= '0;
    else if (cnt_en) cnt <= cnt + 1'b1;
  end
  assign cnt_q = force0 ? '0 : cnt;

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*CW +: CW] = CW'(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; req_len = '0; force0 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst gnt", gnt, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst clr", cnt_clr, 0);
    reset = 1'b1;

    // Test 1: single requester, length 5
    nxt();
    req = 4'b0001; set_len(0, 5);
    #1 chk("t1 c0 gnt", gnt, 0);
    nxt();
    chk("t1 c1 gnt", gnt, 4'b0001);
    chk("t1 c1 clr", cnt_clr, 1);
    chk("t1 c1 busy", busy, 1);
    for (int k = 2; k <= 6; k++) begin
      nxt();
      chk("t1 cnt_q", cnt_q, k - 2);
      chk("t1 cnt_en", cnt_en, (k < 6));
      chk("t1 run done", done, 0);
    end
    nxt();
    chk("t1 c7 done", done, 4'b0001);
    chk("t1 c7 en", cnt_en, 0);
    req = '0;
    nxt();
    chk("t1 c8 busy", busy, 0);
    chk("t1 c8 done", done, 0);

    // Test 2: all request, length 2, starting from rr_ptr 0
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    for (int n = 0; n < 5; n++) begin
      nxt();
      chk("t2 gnt", gnt, 4'b0001 << (n % 4));
      nxt(); nxt(); nxt();
      chk("t2 done", done, 4'b0001 << (n % 4));
      if (n == 4) req = '0;
      nxt();
      chk("t2 idle busy", busy, 0);
    end

    // Test 3: zero length, then length 1
    req = 4'b0100; set_len(2, 0);
    nxt();
    chk("t3a gnt", gnt, 4'b0100);
    chk("t3a en", cnt_en, 0);
    nxt();
    chk("t3a done", done, 4'b0100);
    chk("t3a en2", cnt_en, 0);
    req = '0;
    nxt();
    chk("t3a idle", busy, 0);
    req = 4'b0100; set_len(2, 1);
    nxt();
    chk("t3b gnt", gnt, 4'b0100);
    nxt();
    chk("t3b cnt_q", cnt_q, 0);
    chk("t3b en", cnt_en, 0);
    chk("t3b nodone", done, 0);
    nxt();
    chk("t3b done", done, 4'b0100);
    req = '0;
    nxt();

    // Test 4: withdrawal mid-run with a pending requester
    req = 4'b0110; set_len(1, 10); set_len(2, 2);
    nxt();
    chk("t4 gnt1", gnt, 4'b0010);
    nxt(); nxt(); nxt(); nxt();
    chk("t4 cnt3", cnt_q, 3);
    req = 4'b0100;
    #1 chk("t4 en drop", cnt_en, 0);
    nxt();
    chk("t4 idle busy", busy, 0);
    chk("t4 no done", done, 0);
    chk("t4 cnt hold", cnt_q, 3);
    nxt();
    chk("t4 gnt2", gnt, 4'b0100);
    nxt();
    chk("t4 cnt0", cnt_q, 0);
    nxt(); nxt();
    chk("t4 done2", done, 4'b0100);
    req = '0;
    nxt();

    // Test 5: asynchronous reset mid-run
    req = 4'b0001; set_len(0, 20);
    nxt(); nxt(); nxt();
    chk("t5 running", cnt_en, 1);
    reset = 1'b0;
    #1;
    chk("t5 gnt", gnt, 0);
    chk("t5 busy", busy, 0);
    chk("t5 en", cnt_en, 0);
    chk("t5 clr", cnt_clr, 0);
    chk("t5 done", done, 0);
    req = '0;
    nxt();
    reset = 1'b1;
    req = 4'b0110; set_len(1, 1); set_len(2, 1);
    nxt();
    chk("t5 rr gnt", gnt, 4'b0010);
    nxt(); nxt();
    chk("t5 done1", done, 4'b0010);
    req = '0;
    nxt();

    // Test 6: counter stuck at zero
    force0 = 1'b1;
    req = 4'b1000; set_len(3, 7);
    nxt();
    chk("t6 gnt", gnt, 4'b1000);
    for (int k = 2; k <= 34; k++) begin
      nxt();
      if (k == 2 || k == 34) chk("t6 run en", cnt_en, 1);
    end
    nxt();
`ifdef WATCHDOG_EN
    chk("t6 err", err, 1);
    chk("t6 abort gnt", gnt, 4'b1000);
    chk("t6 abort done", done, 0);
    nxt();
    chk("t6 idle", busy, 0);
    chk("t6 err off", err, 0);
`else
    chk("t6 still busy", busy, 1);
    chk("t6 no err", err, 0);
    chk("t6 no done", done, 0);
    req = '0;
    #1 chk("t6 drop en", cnt_en, 0);
    nxt();
    chk("t6 idle", busy, 0);
`endif
    force0 = 1'b0;
    req = 4'b1001; set_len(0, 1);
    nxt();
    chk("t6 rr gnt", gnt, 4'b0001);
    req = '0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
